// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default baud divisor, parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    // 50 MHz / 115200 baud
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

    // Even parity is the XOR of the data bits; odd parity inverts it.
    // Callers must zero any bits above the active data width.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter. Counts while enabled and pulses bit_end_o on the last cycle
// of each bit period, then wraps to zero. half_i shortens the period to half a bit
// so a receiver can land its first sample mid start bit.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    input  logic half_i,
    output logic bit_end_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] LastFull = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] LastHalf = CntW'(CLKS_PER_BIT / 2 - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cnt_last;

    // Next count and end-of-period pulse
    always_comb begin
        cnt_last  = half_i ? LastHalf : LastFull;
        cnt_d     = cnt_q;
        bit_end_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == cnt_last) begin
                cnt_d     = '0;
                bit_end_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/transmitter_shift_register.sv
// UART TX serializer: loads one byte while idle and shifts out
// start, data (LSB first), optional parity and stop bits on a registered tx line.
module transmitter_shift_register
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       tsr_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [2:0] LastData = 3'(DATA_BITS - 1);
    localparam logic [2:0] LastStop = 3'(STOP_BITS - 1);

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    // Counts data bits in StData, then stop bits in StStop
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        tx_q, tx_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [7:0]  load_data;
    logic        bit_end;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i    (CLK),
        .rst_i    (RST),
        .en_i     (state_q != StIdle),
        .clr_i    (state_q == StIdle),
        .half_i   (1'b0),
        .bit_end_o(bit_end)
    );

    // Drop data bits above the configured width so they never reach parity or tx
    always_comb begin
        load_data = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(DATA_BITS)) begin
                load_data[i] = data_in[i];
            end
        end
    end

    // Frame sequencing; every output is computed one cycle ahead and registered
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        par_d     = par_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (data_valid) begin
                    shift_d   = load_data;
                    par_d     = parity_bit(load_data, PARITY_ODD != 0);
                    bit_cnt_d = '0;
                    state_d   = StStart;
                    tx_d      = 1'b0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LastData) begin
                        bit_cnt_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = StParity;
                            tx_d    = par_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (bit_cnt_q == LastStop) begin
                        bit_cnt_d = '0;
                        state_d   = StIdle;
                        ready_d   = 1'b1;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        tx_d      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tsr_ready = ready_q;
    assign tx        = tx_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;

endmodule

// File: tb/tb_transmitter_shift_register.sv
// Directed bench: four serializer configurations at 4 clocks per bit.
// Index 0 = defaults, 1 = even parity, 2 = odd parity, 3 = two stop bits.
module tb_transmitter_shift_register;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic [3:0] dv;
    logic [3:0] rdy_w, tx_w, busy_w, done_w;

    int n_vec = 0;
    int n_err = 0;

    // Per-instance observations from the last observe() call
    logic [15:0] obs_bits [4];
    int          obs_rdy_low [4];
    int          obs_busy [4];
    int          obs_done [4];
    int          obs_done_cyc [4];
    int          obs_first_rdy [4];
    logic        obs_tx0 [4];

    transmitter_shift_register #(.CLKS_PER_BIT(4)) u_base (
        .CLK(clk), .RST(rst), .data_in(data_in), .data_valid(dv[0]),
        .tsr_ready(rdy_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0])
    );

    transmitter_shift_register #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_par_even (
        .CLK(clk), .RST(rst), .data_in(data_in), .data_valid(dv[1]),
        .tsr_ready(rdy_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1])
    );

    transmitter_shift_register #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_par_odd (
        .CLK(clk), .RST(rst), .data_in(data_in), .data_valid(dv[2]),
        .tsr_ready(rdy_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2])
    );

    transmitter_shift_register #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_stop2 (
        .CLK(clk), .RST(rst), .data_in(data_in), .data_valid(dv[3]),
        .tsr_ready(rdy_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse data_valid for one cycle on the selected instances; returns on frame cycle 0
    task automatic send(input logic [3:0] mask, input logic [7:0] d);
        dv      = mask;
        data_in = d;
        @(negedge clk);
        dv = '0;
    endtask

    // Sample all instances for ncyc cycles; bit k is taken mid-bit at cycle 4k+2.
    // At cycle poke_c a 0xFF strobe is driven into instance 0.
    task automatic observe(input int ncyc, input int poke_c);
        for (int i = 0; i < 4; i++) begin
            obs_bits[i] = '1; obs_rdy_low[i] = 0; obs_busy[i] = 0; obs_done[i] = 0;
            obs_done_cyc[i] = -1; obs_first_rdy[i] = -1; obs_tx0[i] = 1'bx;
        end
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (c == 0) obs_tx0[i] = tx_w[i];
                if ((c % 4 == 2) && (c / 4 < 16)) obs_bits[i][c/4] = tx_w[i];
                if (rdy_w[i] !== 1'b1) obs_rdy_low[i]++;
                else if (obs_first_rdy[i] < 0) obs_first_rdy[i] = c;
                if (busy_w[i] === 1'b1) obs_busy[i]++;
                if (done_w[i] === 1'b1) begin
                    obs_done[i]++;
                    if (obs_done_cyc[i] < 0) obs_done_cyc[i] = c;
                end
            end
            if (c == poke_c) begin
                dv[0]   = 1'b1;
                data_in = 8'hFF;
            end else begin
                dv = '0;
            end
            @(negedge clk);
        end
        dv = '0;
    endtask

    initial begin
        rst     = 1'b1;
        dv      = '0;
        data_in = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_tx", 32'(tx_w[0]), 32'd1);
        chk("rst_ready", 32'(rdy_w[0]), 32'd1);
        chk("rst_busy", 32'(busy_w[0]), 32'd0);
        chk("rst_done", 32'(done_w[0]), 32'd0);
        chk("rst_tx_all", 32'(tx_w), 32'hF);
        rst = 1'b0;
        @(negedge clk);

        // Single frame 0x55
        send(4'b0001, 8'h55);
        observe(44, -1);
        chk("f55_tx0", 32'(obs_tx0[0]), 32'd0);
        chk("f55_bits", 32'(obs_bits[0][10:0]), 32'({2'b11, 8'h55, 1'b0}));
        chk("f55_rdy_low", 32'(obs_rdy_low[0]), 32'd40);
        chk("f55_first_rdy", 32'(obs_first_rdy[0]), 32'd40);
        chk("f55_busy", 32'(obs_busy[0]), 32'd40);
        chk("f55_done_cnt", 32'(obs_done[0]), 32'd1);
        chk("f55_done_cyc", 32'(obs_done_cyc[0]), 32'd40);

        // Parity (even/odd) and two stop bits, all loaded with 0x07
        send(4'b1110, 8'h07);
        observe(48, -1);
        chk("pe_bits", 32'(obs_bits[1][11:0]), 32'({2'b11, 1'b1, 8'h07, 1'b0}));
        chk("pe_first_rdy", 32'(obs_first_rdy[1]), 32'd44);
        chk("pe_done_cyc", 32'(obs_done_cyc[1]), 32'd44);
        chk("po_bits", 32'(obs_bits[2][11:0]), 32'({2'b11, 1'b0, 8'h07, 1'b0}));
        chk("po_first_rdy", 32'(obs_first_rdy[2]), 32'd44);
        chk("s2_bits", 32'(obs_bits[3][11:0]), 32'({3'b111, 8'h07, 1'b0}));
        chk("s2_first_rdy", 32'(obs_first_rdy[3]), 32'd44);
        chk("s2_done_cnt", 32'(obs_done[3]), 32'd1);
        chk("s2_done_cyc", 32'(obs_done_cyc[3]), 32'd44);
        chk("idle_base_during_par", 32'(obs_busy[0]), 32'd0);

        // Back-to-back: 0xA3 then 0x3C loaded on the first ready cycle
        send(4'b0001, 8'hA3);
        observe(40, -1);
        chk("a3_bits", 32'(obs_bits[0][9:0]), 32'({1'b1, 8'hA3, 1'b0}));
        chk("a3_rdy_low", 32'(obs_rdy_low[0]), 32'd40);
        chk("a3_rdy_rise", 32'(rdy_w[0]), 32'd1);
        chk("a3_done", 32'(done_w[0]), 32'd1);
        chk("gap_tx", 32'(tx_w[0]), 32'd1);
        send(4'b0001, 8'h3C);
        observe(44, -1);
        chk("3c_tx0", 32'(obs_tx0[0]), 32'd0);
        chk("3c_bits", 32'(obs_bits[0][10:0]), 32'({2'b11, 8'h3C, 1'b0}));
        chk("3c_first_rdy", 32'(obs_first_rdy[0]), 32'd40);
        chk("3c_done_cnt", 32'(obs_done[0]), 32'd1);

        // Mid-frame strobe of 0xFF while sending 0x00 must be ignored
        send(4'b0001, 8'h00);
        observe(60, 20);
        chk("m00_bits", 32'(obs_bits[0][14:0]), 32'({6'b111111, 8'h00, 1'b0}));
        chk("m00_rdy_low", 32'(obs_rdy_low[0]), 32'd40);
        chk("m00_done_cnt", 32'(obs_done[0]), 32'd1);

        // Reset during data bit 3 of 0x81 (frame cycles 16..19)
        send(4'b0001, 8'h81);
        observe(17, -1);
        chk("ab_no_done", 32'(obs_done[0]), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ab_tx", 32'(tx_w[0]), 32'd1);
        chk("ab_ready", 32'(rdy_w[0]), 32'd1);
        chk("ab_busy", 32'(busy_w[0]), 32'd0);
        chk("ab_done", 32'(done_w[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ab_done_after", 32'(done_w[0]), 32'd0);
        send(4'b0001, 8'h81);
        observe(44, -1);
        chk("r81_bits", 32'(obs_bits[0][10:0]), 32'({2'b11, 8'h81, 1'b0}));
        chk("r81_first_rdy", 32'(obs_first_rdy[0]), 32'd40);
        chk("r81_done_cnt", 32'(obs_done[0]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
